// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Holds the FSM state encoding, the Booth digit set and the digit-count function.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // One digit per bit pair of the 2-bit-extended multiplier.
    function automatic int booth_digits(input int data_width);
        return data_width / 2 + 1;
    endfunction

endpackage

// File: rtl/mul_booth_radix4_enc.sv
// Radix-4 Booth digit encoder: 3 multiplier bits -> digit and sign-extended partial product.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module mul_booth_radix4_enc
    import mul_pkg::*;
#(
    parameter int XW = 10,
    parameter int AW = 18
) (
    input  logic [2:0]    y_bits,
    input  logic [XW-1:0] x_ext,
    output booth_digit_e  digit,
    output logic [AW-1:0] pp
);

    logic [AW-1:0] x_se;

    assign x_se = {{(AW - XW){x_ext[XW-1]}}, x_ext};

    always_comb begin
        digit = ZERO;
        pp    = '0;
        case (y_bits)
            3'b001, 3'b010: begin
                digit = POS1;
                pp    = x_se;
            end
            3'b011: begin
                digit = POS2;
                pp    = x_se << 1;
            end
            3'b100: begin
                digit = NEG2;
                pp    = -(x_se << 1);
            end
            3'b101, 3'b110: begin
                digit = NEG1;
                pp    = -x_se;
            end
            default: begin
                digit = ZERO;
                pp    = '0;
            end
        endcase
    end

endmodule

// File: rtl/mul_radix4_booth.sv
// Iterative radix-4 Booth multiplier, signed/unsigned selectable per operation (MUL_BOOTH_EARLY_END_EN: early termination).
// Latency: DATA_WIDTH/2+1 cycles from accept to o_valid; 1..N cycles with MUL_BOOTH_EARLY_END_EN.
// Backpressure: result held in DONE until i_ready; o_ready stays low until the result is taken.
module mul_radix4_booth
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_signed,
    input  logic [DATA_WIDTH-1:0]   i_num_x,
    input  logic [DATA_WIDTH-1:0]   i_num_y,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*DATA_WIDTH-1:0] o_res,
    output logic                    o_busy
);

    localparam int XW = DATA_WIDTH + 2;
    localparam int AW = 2 * DATA_WIDTH + 2;
    localparam int N  = booth_digits(DATA_WIDTH);
    localparam int IW = $clog2(N);

    generate
        if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
            $error("mul_radix4_booth: DATA_WIDTH must be even and at least 4");
        end
    endgenerate

    mul_state_e    state, state_n;
    logic [XW-1:0] x_q, y_q;
    logic [XW-1:0] x_in, y_in;
    logic [AW-1:0] acc_q;
    logic [IW-1:0] idx_q;
    logic          ready_q, valid_q, busy_q;
    logic          accept, calc_end;
    logic [XW:0]   y_win;
    booth_digit_e  digit;
    logic [AW-1:0] pp, pp_sh;
    logic          acc_unused;

    assign accept = i_valid & ready_q;

    // Two extra bits make the top digit well defined for full-range unsigned operands.
    assign x_in = i_signed ? {{2{i_num_x[DATA_WIDTH-1]}}, i_num_x} : {2'b00, i_num_x};
    assign y_in = i_signed ? {{2{i_num_y[DATA_WIDTH-1]}}, i_num_y} : {2'b00, i_num_y};

    // Appended zero is y[-1]; shifting by 2*idx puts the current triplet at [2:0].
    assign y_win = {y_q, 1'b0} >> {idx_q, 1'b0};

    mul_booth_radix4_enc #(
        .XW (XW),
        .AW (AW)
    ) u_enc (
        .y_bits (y_win[2:0]),
        .x_ext  (x_q),
        .digit  (digit),
        .pp     (pp)
    );

    assign pp_sh = pp << {idx_q, 1'b0};

`ifdef MUL_BOOTH_EARLY_END_EN
    // Remaining digits are all zero once y[XW-1:2i+1] is a run of identical bits.
    logic [XW-1:0] y_hi;
    assign y_hi     = $signed(y_q) >>> {idx_q, 1'b1};
    assign calc_end = (idx_q == IW'(N - 1)) || (y_hi == '0) || (y_hi == '1);
`else
    assign calc_end = (idx_q == IW'(N - 1));
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept)   state_n = CALC;
            CALC:    if (calc_end) state_n = DONE;
            DONE:    if (i_ready)  state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE);
            valid_q <= (state_n == DONE);
            busy_q  <= (state_n == CALC);
            if (accept) begin
                x_q   <= x_in;
                y_q   <= y_in;
                acc_q <= '0;
                idx_q <= '0;
            end else if (state == CALC) begin
                if (digit != ZERO) begin
                    acc_q <= acc_q + pp_sh;
                end
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Guard bits of the accumulator only absorb the modular wrap.
    assign acc_unused = ^acc_q[AW-1:2*DATA_WIDTH];

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_res   = acc_q[2*DATA_WIDTH-1:0];

endmodule

// File: tb/tb_mul_radix4_booth.sv
// Bench for mul_radix4_booth: DATA_WIDTH=4 and DATA_WIDTH=8 instances against an integer product model.
module tb_mul_radix4_booth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [1:0] in_vld, in_sgn, cons_rdy;
    logic [7:0] in_x [2];
    logic [7:0] in_y [2];
    logic [1:0] o_rdy, o_vld, o_bsy;
    logic [7:0]  res4;
    logic [15:0] res8;
    logic        bp_hold;

    mul_radix4_booth #(.DATA_WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld[0]), .o_ready(o_rdy[0]),
        .i_signed(in_sgn[0]), .i_num_x(in_x[0][3:0]), .i_num_y(in_y[0][3:0]),
        .o_valid(o_vld[0]), .i_ready(cons_rdy[0]), .o_res(res4), .o_busy(o_bsy[0])
    );

    mul_radix4_booth #(.DATA_WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_vld[1]), .o_ready(o_rdy[1]),
        .i_signed(in_sgn[1]), .i_num_x(in_x[1]), .i_num_y(in_y[1]),
        .o_valid(o_vld[1]), .i_ready(cons_rdy[1]), .o_res(res8), .o_busy(o_bsy[1])
    );

    typedef struct {
        logic [15:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int width_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic longint op_value(input int w, input bit sgn, input logic [7:0] v);
        longint a;
        a = longint'(v) & ((longint'(1) << w) - 1);
        if (sgn && a[w-1]) a = a - (longint'(1) << w);
        return a;
    endfunction

    function automatic logic [15:0] ref_mul(input int w, input bit sgn, input logic [7:0] x, input logic [7:0] y);
        longint p;
        p = op_value(w, sgn, x) * op_value(w, sgn, y);
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    function automatic int ref_lat(input int w, input bit sgn, input logic [7:0] y);
        int n;
        n = w / 2 + 1;
`ifdef MUL_BOOTH_EARLY_END_EN
        begin
            longint yv;
            yv = op_value(w, sgn, y);
            for (int i = 0; i < n; i++) begin
                if ((yv >>> (2 * i + 1)) == 0 || (yv >>> (2 * i + 1)) == -1) return i + 1;
            end
        end
`endif
        return n;
    endfunction

    function automatic logic [15:0] get_res(input int k);
        return (k == 0) ? {8'h00, res4} : res8;
    endfunction

    task automatic issue(input int k, input bit sgn, input logic [7:0] x, input logic [7:0] y);
        int   guard;
        int   w;
        exp_t e;
        guard     = 0;
        w         = width_of(k);
        in_sgn[k] = sgn;
        in_x[k]   = x;
        in_y[k]   = y;
        in_vld[k] = 1'b1;
        while (!o_rdy[k] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_rdy[k]) begin
            check(1'b0, "accept_timeout", guard, 0);
            in_vld[k] = 1'b0;
            return;
        end
        e.res = ref_mul(w, sgn, x, y);
        e.acc = cyc + 1;
        e.lat = ref_lat(w, sgn, y);
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(negedge clk);
        in_vld[k] = 1'b0;
        in_sgn[k] = 1'($urandom);
        in_x[k]   = 8'($urandom);
        in_y[k]   = 8'($urandom);
        check(o_bsy[k] == 1'b1, "busy_after_accept", o_bsy[k], 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || o_vld != 2'b00) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(t < 400, "drain_timeout", t, 0);
    endtask

    logic [1:0]  seen    = '0;
    logic [1:0]  hs_pend = '0;
    logic [15:0] held [2];

    task automatic mon_step(input int k);
        logic [15:0] r;
        exp_t        e;
        bit          have;
        r = get_res(k);
        if (hs_pend[k]) begin
            hs_pend[k] = 1'b0;
            seen[k]    = 1'b0;
            check(!o_vld[k] && o_rdy[k], "after_handshake", {o_vld[k], o_rdy[k]}, 2'b01);
        end else if (o_vld[k]) begin
            check(!o_rdy[k], "ready_in_done", o_rdy[k], 0);
            if (!seen[k]) begin
                seen[k] = 1'b1;
                held[k] = r;
                have    = 1'b0;
                if (k == 0 && sb0.size() != 0) begin
                    e = sb0.pop_front();
                    have = 1'b1;
                end else if (k == 1 && sb1.size() != 0) begin
                    e = sb1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    check(1'b0, "unexpected_result", r, 0);
                end else begin
                    check(r == e.res, (k == 0) ? "result_w4" : "result_w8", r, e.res);
                    check(cyc - e.acc == e.lat, "latency", cyc - e.acc, e.lat);
                end
            end else begin
                check(r == held[k], "result_hold", r, held[k]);
            end
            if (cons_rdy[k]) hs_pend[k] = 1'b1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    initial begin
        cons_rdy = 2'b11;
        forever begin
            @(negedge clk);
            if (!bp_hold) cons_rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
        end
    end

    task automatic random_ops(input int k, input int count);
        logic [7:0] y;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 3))
                0:       y = 8'($urandom_range(0, 3));
                1:       y = 8'hFF ^ 8'($urandom_range(0, 3));
                default: y = 8'($urandom);
            endcase
            issue(k, 1'($urandom), 8'($urandom), y);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n   = 1'b0;
        bp_hold = 1'b0;
        in_vld  = 2'b00;
        in_sgn  = 2'b00;
        in_x[0] = '0; in_x[1] = '0;
        in_y[0] = '0; in_y[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check(o_rdy[k] == 1'b0, "reset_ready", o_rdy[k], 0);
            check(o_vld[k] == 1'b0, "reset_valid", o_vld[k], 0);
            check(o_bsy[k] == 1'b0, "reset_busy", o_bsy[k], 0);
            check(get_res(k) == 16'h0, "reset_res", get_res(k), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check(o_rdy == 2'b11, "ready_after_reset", o_rdy, 2'b11);

        issue(0, 1'b1, 8'h0A, 8'h09);
        issue(0, 1'b0, 8'h0A, 8'h09);
        issue(0, 1'b1, 8'h0A, 8'h05);
        issue(0, 1'b0, 8'h0A, 8'h05);
        issue(1, 1'b1, 8'h80, 8'h80);
        issue(1, 1'b0, 8'hFF, 8'hFF);
        issue(1, 1'b0, 8'h37, 8'h01);
        issue(1, 1'b1, 8'h37, 8'hFF);
        issue(1, 1'b0, 8'h37, 8'h80);
        drain();

        // Consumer stalls for 4 cycles with stray request pulses on the input side.
        bp_hold     = 1'b1;
        cons_rdy[1] = 1'b0;
        issue(1, 1'b1, 8'hC5, 8'h6B);
        t = 0;
        while (!o_vld[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(o_vld[1] == 1'b1, "bp_valid_seen", o_vld[1], 1);
        for (int i = 0; i < 4; i++) begin
            in_vld[1] = 1'($urandom_range(0, 1));
            in_x[1]   = 8'($urandom);
            in_y[1]   = 8'($urandom);
            check(o_rdy[1] == 1'b0, "bp_ready_low", o_rdy[1], 0);
            @(negedge clk);
        end
        in_vld[1]   = 1'b0;
        cons_rdy[1] = 1'b1;
        bp_hold     = 1'b0;
        drain();

        fork
            random_ops(0, 120);
            random_ops(1, 120);
        join
        drain();

        // Reset lands on the second CALC cycle; the partial result must vanish.
        issue(1, 1'b0, 8'h37, 8'h85);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(o_rdy[1] == 1'b0, "midrst_ready", o_rdy[1], 0);
        check(o_vld[1] == 1'b0, "midrst_valid", o_vld[1], 0);
        check(o_bsy[1] == 1'b0, "midrst_busy", o_bsy[1], 0);
        check(res8 == 16'h0, "midrst_res", res8, 0);
        sb1.delete();
        repeat (2) @(negedge clk);
        check(o_rdy[1] == 1'b0, "held_rst_ready", o_rdy[1], 0);
        rst_n = 1'b1;
        #1;
        check(o_rdy[1] == 1'b0, "ready_before_edge", o_rdy[1], 0);
        @(negedge clk);
        check(o_rdy[1] == 1'b1, "ready_after_release", o_rdy[1], 1);
        issue(1, 1'b1, 8'h9C, 8'hD3);
        issue(0, 1'b1, 8'h08, 8'h08);
        random_ops(1, 10);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_radix4_booth.md
# mul_radix4_booth

Parametrised radix-4 Booth multiplier: successor to the single-shot 2n-bit Booth multiplier in the `calc/mul` tree. It adds a valid/ready handshake on both sides, runtime signed/unsigned selection, arbitrary even operand width, and back-to-back operation without reset pulses. Each cycle retires one radix-4 digit, roughly halving latency. Sits beside the other `calc/mul` multipliers as the default iterative multiplier for datapath use.

## Interface
- `DATA_WIDTH`, default 8: operand width. Must be even and ≥ 4; any other value is an elaboration error.
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_valid` input 1: operands valid.
- `o_ready` output 1: block can accept operands.
- `i_signed` input 1: 1 = two's-complement operands, 0 = unsigned. Sampled with the operands.
- `i_num_x` input DATA_WIDTH: multiplicand.
- `i_num_y` input DATA_WIDTH: multiplier.
- `o_valid` output 1: result valid.
- `i_ready` input 1: consumer accepts result.
- `o_res` output 2*DATA_WIDTH: product, signed or unsigned per captured `i_signed`.
- `o_busy` output 1: high in CALC.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- **IDLE:** `o_ready`=1. On `i_valid & o_ready`:
  - capture X and Y extended to DATA_WIDTH+2 bits (sign-extend if `i_signed`, else zero-extend);
  - clear accumulator (2*DATA_WIDTH+2 bits) and digit index;
  - go to CALC.
- **CALC:** digit i (i = 0..N-1, N = DATA_WIDTH/2+1) from Y bits {y[2i+1], y[2i], y[2i-1]}, y[-1]=0. Encoding:
  - 000/111 → 0
  - 001/010 → +1
  - 011 → +2
  - 100 → −2
  - 101/110 → −1
- Add digit·X, sign-extended, shifted left by 2i, into the accumulator, modulo 2^(2*DATA_WIDTH+2).
- After digit N-1, go to DONE.
- **DONE:** `o_valid`=1, `o_res` = accumulator[2*DATA_WIDTH-1:0], held stable until `o_valid & i_ready`, then IDLE.
- `o_ready` is 1 only in IDLE. No overlap of a new accept with an unconsumed result.
- Operand inputs are ignored outside the IDLE accept edge. Changing them mid-operation has no effect.
- `i_valid` high with `o_ready` low is not an error; the request waits.
- `i_ready` outside DONE is ignored.
- Full-range cases are exact, e.g. signed −2^(W−1) · −2^(W−1) = 2^(2W−2).

## Timing
- Reset values: `o_ready`=0 while `i_rst_n`=0, 1 on the first cycle after release. `o_valid`=0, `o_busy`=0, `o_res`=0. Internal state is IDLE.
- Assertion of `i_rst_n`=0 in any state clears everything immediately. An in-flight operation is discarded with no `o_valid`.
- Accept at edge k → `o_busy` high from k. Without early end, `o_valid` rises after edge k+N. DATA_WIDTH=8 gives 5 cycles; DATA_WIDTH=4 gives 3.
- Result handshake at edge m → `o_valid` low and `o_ready` high after m. The earliest next accept is edge m+1.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- `MUL_BOOTH_EARLY_END_EN` defined: after processing digit i, if y[DATA_WIDTH+1:2i+1] are all equal, every remaining digit is 0 and CALC goes to DONE on that edge. CALC always lasts at least 1 cycle. Latency varies from 1 to N cycles; the result is identical.
- Undefined: fixed N-cycle CALC and no comparison logic.

## Structure
- Package `mul_pkg` contains:
  - `mul_state_e` (IDLE/CALC/DONE);
  - `booth_digit_e` (ZERO, POS1, POS2, NEG1, NEG2);
  - a function computing N from DATA_WIDTH.
- Sub-module `mul_booth_radix4_enc` is combinational. It takes 3 Y bits and the extended X, and returns the digit and the sign-extended partial product.
- Top-level contains the FSM, the index counter, the accumulator and the early-end check.

## Test plan
- DATA_WIDTH=4, signed, X=1010, Y=1001 → `o_res`=8'h2A (−6·−7=42), `o_valid` 3 cycles after accept (without macro).
- DATA_WIDTH=4, unsigned, X=1010, Y=1001 → 8'h5A; same operands with Y=0101 give signed 8'hE2 and unsigned 8'h32.
- DATA_WIDTH=8, signed, X=Y=8'h80 → 16'h4000. Unsigned X=Y=8'hFF → 16'hFE01.
- Backpressure: hold `i_ready`=0 for 4 cycles in DONE → `o_res`/`o_valid` stable, `o_ready`=0, `i_valid` pulses ignored. Release → IDLE next cycle. Back-to-back requests are each accepted exactly once.
- Reset mid-CALC: drop `i_rst_n` at cycle 2 of an operation → outputs go to reset values immediately, no `o_valid`. A fresh operation after release is correct.
- With `MUL_BOOTH_EARLY_END_EN`: DATA_WIDTH=8, unsigned, Y=8'h01, X=8'h37 → `o_res`=16'h0037 after 1 CALC cycle. Y=8'hFF signed (−1) → 1 cycle, `o_res`=−X. Y=8'h80 unsigned → full 5 cycles.
